uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
UART receiver, 8N1 framing, LSB first, idle-high line; the counterpart to the team's uart_tx.
- Oversamples rx_i at CLKS_PER_BIT clocks per bit and validates the start bit at mid-bit.
- Samples 8 data bits and the stop bit at mid-bit.
- Presents each good byte with a one-cycle valid strobe; flags bad stop bits as framing errors.
- Sits between the board RX pin and the command/loopback logic.

Parameters:
CLKS_PER_BIT, 4, clk cycles per UART bit; legal range >= 2.

Ports:
clk  input  1  system clock
resetn  input  1  synchronous, active-low reset
rx_i  input  1  asynchronous serial line, idle high
d_o  output  8  last correctly received byte
v_o  output  1  one-cycle strobe: d_o updated with a new good byte
frame_err_o  output  1  one-cycle strobe: stop bit sampled low
busy_o  output  1  high while a frame is in progress

Behaviour:
- Clock and reset: reset resetn, synchronous, active-low; clock clk.
- Synchronizer:
  - rx_i passes through a 2-flop synchronizer; its output is rx_s. Both flops reset to 1.
  - All logic below uses rx_s only. Latency from rx_i to rx_s is 2 cycles.
- Constants: H = (CLKS_PER_BIT-1)/2, integer division. Timer width = $clog2(CLKS_PER_BIT), minimum 1.
- Reset values: d_o=0, v_o=0, frame_err_o=0, busy_o=0, bit_idx=0, state=WAIT_IDLE, idle counter=0.
- Timer rule: in START, DATA and STOP the timer decrements every cycle. The "sample edge" is the edge where timer==0.
- States:
  - WAIT_IDLE:
    - Counts consecutive cycles with rx_s==1; any rx_s==0 clears the count.
    - After CLKS_PER_BIT consecutive high cycles -> IDLE.
    - Guarantees that no false start is taken when the line is low at reset release or after a break.
  - IDLE:
    - rx_s==0 -> START, timer loaded with H, busy_o<=1.
  - START:
    - Sample edge with rx_s==0 -> DATA, timer<=CLKS_PER_BIT-1, bit_idx<=0.
    - Sample edge with rx_s==1 -> glitch: IDLE, busy_o<=0, no strobe.
  - DATA:
    - On the sample edge, shift register[bit_idx]<=rx_s and timer<=CLKS_PER_BIT-1.
    - If bit_idx==7 -> STOP; otherwise bit_idx++.
  - STOP, on the sample edge:
    - rx_s==1: d_o<=shift register, v_o<=1 for exactly one cycle, busy_o<=0, -> IDLE.
    - rx_s==0: frame_err_o<=1 for exactly one cycle, d_o unchanged, v_o stays 0, busy_o<=0, -> WAIT_IDLE.
- Timing:
  - Cycles spent in START = H+1; each data bit and the stop bit take CLKS_PER_BIT cycles.
  - v_o/frame_err_o are high in the cycle after the stop sample edge.
  - If IDLE->START happens at edge E0, v_o is high after edge E0 + H+1 + 9*CLKS_PER_BIT. For CLKS_PER_BIT=4 that is edge E0+38.
- Strobe rules:
  - v_o and frame_err_o are never high together.
  - Neither is high for more than one cycle per frame.
- Back-to-back frames: from IDLE, a new falling edge is accepted in the cycle after the stop sample. No idle gap is required beyond the stop bit.
- d_o holds its value between frames. It changes only together with a v_o pulse.
- Reset mid-frame:
  - Aborts immediately; outputs return to reset values; no strobe.
  - The receiver must see CLKS_PER_BIT idle cycles before accepting a new start.
- rx_i changes between sample edges are ignored. Only the mid-bit sample matters.

Test Plan:
1. CLKS_PER_BIT=4: send 0xA5 as 8N1 LSB first after reset and 4+ idle cycles -> v_o high exactly 1 cycle, 38 edges after the START entry; d_o=0xA5; frame_err_o=0; busy_o high only while in START/DATA/STOP.
2. Send 0x00, then 0xFF with no gap after the stop bit -> two v_o pulses, d_o=0x00 then 0xFF; the second frame's START is entered within 1 cycle of the line falling (after the sync delay).
3. Drive rx_i low for 1 clk while idle -> START entered, then back to IDLE; no v_o, no frame_err_o; busy_o drops after H+1 cycles.
4. Send 0x3C with the stop bit driven low, line held low for 20 cycles -> frame_err_o one pulse, d_o keeps its previous value, no v_o. After release, the receiver waits 4 high cycles; a following 0x81 is received correctly.
5. Assert resetn=0 for 1 cycle during data bit 4 of a frame -> d_o=0, busy_o=0, no strobe. The remainder of the aborted frame produces no v_o, and a fresh 0x5A sent afterwards gives d_o=0x5A.
6. CLKS_PER_BIT=16: send 0x96 with a 2-cycle glitch at the edge of each bit -> d_o=0x96, v_o once.

Source files
------------

// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop synchronizer, mid-bit sampling, one-cycle valid and
// framing-error strobes. A full bit time of idle line is required before any start is taken.
module uart_rx #(
  parameter int unsigned CLKS_PER_BIT = 4
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       rx_i,
  output logic [7:0] d_o,
  output logic       v_o,
  output logic       frame_err_o,
  output logic       busy_o
);

  localparam int unsigned TimerW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [TimerW-1:0] HalfBit = TimerW'((CLKS_PER_BIT - 1) / 2);
  localparam logic [TimerW-1:0] FullBit = TimerW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    StWaitIdle,
    StIdle,
    StStart,
    StData,
    StStop
  } state_e;

  logic              r_sync1;
  logic              r_sync2;
  state_e            r_state;
  logic [TimerW-1:0] r_timer;
  logic [TimerW-1:0] r_idle_cnt;
  logic [2:0]        r_bit_idx;
  logic [7:0]        r_shift;
  logic [7:0]        r_data;
  logic              r_valid;
  logic              r_ferr;
  logic              r_busy;

  state_e            w_state_d;
  logic [TimerW-1:0] w_timer_d;
  logic [TimerW-1:0] w_idle_cnt_d;
  logic [2:0]        w_bit_idx_d;
  logic [7:0]        w_shift_d;
  logic [7:0]        w_data_d;
  logic              w_valid_d;
  logic              w_ferr_d;
  logic              w_busy_d;
  logic              w_rx_s;
  logic              w_sample;

  assign w_rx_s   = r_sync2;
  assign w_sample = (r_timer == '0);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_sync1    <= 1'b1;
      r_sync2    <= 1'b1;
      r_state    <= StWaitIdle;
      r_timer    <= '0;
      r_idle_cnt <= '0;
      r_bit_idx  <= '0;
      r_shift    <= '0;
      r_data     <= '0;
      r_valid    <= 1'b0;
      r_ferr     <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_sync1    <= rx_i;
      r_sync2    <= r_sync1;
      r_state    <= w_state_d;
      r_timer    <= w_timer_d;
      r_idle_cnt <= w_idle_cnt_d;
      r_bit_idx  <= w_bit_idx_d;
      r_shift    <= w_shift_d;
      r_data     <= w_data_d;
      r_valid    <= w_valid_d;
      r_ferr     <= w_ferr_d;
      r_busy     <= w_busy_d;
    end
  end

  always_comb begin
    w_state_d    = r_state;
    w_timer_d    = r_timer;
    w_idle_cnt_d = r_idle_cnt;
    w_bit_idx_d  = r_bit_idx;
    w_shift_d    = r_shift;
    w_data_d     = r_data;
    w_valid_d    = 1'b0;
    w_ferr_d     = 1'b0;
    w_busy_d     = r_busy;

    case (r_state)
      StWaitIdle: begin
        // Any low cycle restarts the idle qualification.
        if (!w_rx_s) begin
          w_idle_cnt_d = '0;
        end else if (r_idle_cnt == FullBit) begin
          w_idle_cnt_d = '0;
          w_state_d    = StIdle;
        end else begin
          w_idle_cnt_d = r_idle_cnt + 1'b1;
        end
      end
      StIdle: begin
        if (!w_rx_s) begin
          w_state_d = StStart;
          w_timer_d = HalfBit;
          w_busy_d  = 1'b1;
        end
      end
      StStart: begin
        if (!w_sample) begin
          w_timer_d = r_timer - 1'b1;
        end else if (!w_rx_s) begin
          w_state_d   = StData;
          w_timer_d   = FullBit;
          w_bit_idx_d = '0;
        end else begin
          w_state_d = StIdle;
          w_busy_d  = 1'b0;
        end
      end
      StData: begin
        if (!w_sample) begin
          w_timer_d = r_timer - 1'b1;
        end else begin
          w_shift_d[r_bit_idx] = w_rx_s;
          w_timer_d            = FullBit;
          if (r_bit_idx == 3'd7) begin
            w_state_d = StStop;
          end else begin
            w_bit_idx_d = r_bit_idx + 3'd1;
          end
        end
      end
      StStop: begin
        if (!w_sample) begin
          w_timer_d = r_timer - 1'b1;
        end else begin
          w_busy_d = 1'b0;
          if (w_rx_s) begin
            w_data_d  = r_shift;
            w_valid_d = 1'b1;
            w_state_d = StIdle;
          end else begin
            w_ferr_d     = 1'b1;
            w_idle_cnt_d = '0;
            w_state_d    = StWaitIdle;
          end
        end
      end
      default: w_state_d = StWaitIdle;
    endcase
  end

  assign d_o         = r_data;
  assign v_o         = r_valid;
  assign frame_err_o = r_ferr;
  assign busy_o      = r_busy;

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: two instances (4 and 16 clocks per bit), randomized frames,
// expected strobes and their arrival cycles derived from the frame timing rules.
module tb_uart_rx;

  localparam int CpbA = 4;
  localparam int CpbB = 16;
  localparam int HA   = (CpbA - 1) / 2;

  typedef struct {
    bit         ferr;
    logic [7:0] data;
    int         cyc;
  } exp_t;

  logic       clk    = 1'b0;
  logic       resetn = 1'b0;
  logic       rx_a   = 1'b1;
  logic       rx_b   = 1'b1;
  logic [7:0] d_a, d_b;
  logic       v_a, v_b, fe_a, fe_b, busy_a, busy_b;

  int         total = 0;
  int         bad   = 0;
  int         cyc   = 0;
  bit         rst_edge = 1'b1;
  exp_t       q_a[$];
  exp_t       q_b[$];
  logic [7:0] last_a = 8'h00;
  logic [7:0] last_b = 8'h00;

  uart_rx #(.CLKS_PER_BIT(CpbA)) u_dut_a (
    .clk        (clk),
    .resetn     (resetn),
    .rx_i       (rx_a),
    .d_o        (d_a),
    .v_o        (v_a),
    .frame_err_o(fe_a),
    .busy_o     (busy_a)
  );

  uart_rx #(.CLKS_PER_BIT(CpbB)) u_dut_b (
    .clk        (clk),
    .resetn     (resetn),
    .rx_i       (rx_b),
    .d_o        (d_b),
    .v_o        (v_b),
    .frame_err_o(fe_b),
    .busy_o     (busy_b)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rst_edge <= !resetn;
  end

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic mon_port(input int sel, input logic v, input logic fe, input logic [7:0] d,
                          input logic busy);
    exp_t e;
    bit   have;
    if (v || fe) begin
      total++;
      have = (sel == 0) ? (q_a.size() != 0) : (q_b.size() != 0);
      if (!have) begin
        bad++;
        $display("FAIL unexpected_strobe port%0d: v=%0b fe=%0b d=0x%0h cycle=%0d want no strobe",
                 sel, v, fe, d, cyc);
      end else begin
        if (sel == 0) e = q_a.pop_front();
        else          e = q_b.pop_front();
        if (v == e.ferr || fe != e.ferr || d != e.data || busy || cyc != e.cyc) begin
          bad++;
          $display("FAIL strobe port%0d: v=%0b fe=%0b d=0x%0h busy=%0b cycle=%0d want v=%0b fe=%0b d=0x%0h busy=0 cycle=%0d",
                   sel, v, fe, d, busy, cyc, !e.ferr, e.ferr, e.data, e.cyc);
        end
      end
    end
  endtask

  // Monitor: pops the scoreboard on every strobe, and checks d_o only moves with v_o.
  initial begin
    logic [7:0] pa, pb;
    pa = 8'h00;
    pb = 8'h00;
    forever begin
      @(negedge clk);
      mon_port(0, v_a, fe_a, d_a, busy_a);
      mon_port(1, v_b, fe_b, d_b, busy_b);
      if (!rst_edge && !v_a && d_a != pa) begin
        total++;
        bad++;
        $display("FAIL d_hold port0: got 0x%0h want 0x%0h", d_a, pa);
      end
      if (!rst_edge && !v_b && d_b != pb) begin
        total++;
        bad++;
        $display("FAIL d_hold port1: got 0x%0h want 0x%0h", d_b, pb);
      end
      pa = d_a;
      pb = d_b;
    end
  end

  task automatic drive(input int sel, input logic val);
    if (sel == 0) rx_a = val;
    else          rx_b = val;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drives one frame from a negedge; optionally inverts the last 2 cycles of start/data bits.
  task automatic send(input int sel, input logic [7:0] b, input bit stop_v, input bit glitch,
                      input bit expect_ev);
    int         cpb, h, c0;
    logic [9:0] bits;
    logic       lv;
    exp_t       e;
    cpb  = (sel == 0) ? CpbA : CpbB;
    h    = (cpb - 1) / 2;
    bits = {stop_v, b, 1'b0};
    c0   = cyc;
    if (expect_ev) begin
      e.ferr = !stop_v;
      e.data = stop_v ? b : ((sel == 0) ? last_a : last_b);
      e.cyc  = c0 + 3 + h + 1 + 9 * cpb;
      if (sel == 0) q_a.push_back(e);
      else          q_b.push_back(e);
      if (stop_v && sel == 0) last_a = b;
      if (stop_v && sel != 0) last_b = b;
    end
    for (int k = 0; k < 10; k++) begin
      for (int i = 0; i < cpb; i++) begin
        lv = bits[k];
        if (glitch && k < 9 && i >= cpb - 2) lv = ~lv;
        drive(sel, lv);
        @(negedge clk);
        if (k == 0 && i == 2) check("busy_start", (sel == 0) ? busy_a : busy_b, 1);
      end
    end
  endtask

  initial begin
    logic [7:0] b;
    bit         bad_stop;
    int         c0;

    repeat (3) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    check("rst_d_a", d_a, 0);
    check("rst_v_a", v_a, 0);
    check("rst_fe_a", fe_a, 0);
    check("rst_busy_a", busy_a, 0);
    check("rst_d_b", d_b, 0);
    check("rst_busy_b", busy_b, 0);
    idle(6);

    send(0, 8'hA5, 1'b1, 1'b0, 1'b1);
    idle(2);

    // Back-to-back frames with no gap after the stop bit.
    send(0, 8'h00, 1'b1, 1'b0, 1'b1);
    send(0, 8'hFF, 1'b1, 1'b0, 1'b1);
    idle(3);

    // One-cycle low pulse: false start, rejected at the start-bit sample.
    c0 = cyc;
    drive(0, 1'b0);
    @(negedge clk);
    drive(0, 1'b1);
    repeat (2) @(negedge clk);
    check("glitch_busy_set", busy_a, 1);
    repeat (HA) @(negedge clk);
    check("glitch_busy_hold", busy_a, 1);
    @(negedge clk);
    check("glitch_busy_drop", busy_a, 0);
    check("glitch_cycle", cyc - c0, 3 + HA + 1);
    idle(4);

    // Framing error, line held low, then recovery.
    send(0, 8'h3C, 1'b0, 1'b0, 1'b1);
    idle(20);
    drive(0, 1'b1);
    idle(6);
    send(0, 8'h81, 1'b1, 1'b0, 1'b1);
    idle(2);

    // Reset during data bit 4; upper nibble zero so the remainder never looks idle.
    b = 8'($urandom_range(15));
    fork
      send(0, b, 1'b1, 1'b0, 1'b0);
      begin
        repeat (21) @(negedge clk);
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        check("abort_d", d_a, 0);
        check("abort_busy", busy_a, 0);
        check("abort_v", v_a, 0);
        last_a = 8'h00;
        last_b = 8'h00;
      end
    join
    idle(8);
    send(0, 8'h5A, 1'b1, 1'b0, 1'b1);
    idle(1);
    check("fresh_d", d_a, 8'h5A);

    for (int n = 0; n < 16; n++) begin
      bad_stop = ($urandom_range(7) == 0);
      send(0, 8'($urandom_range(255)), !bad_stop, 1'b0, 1'b1);
      if (bad_stop) begin
        idle(1);
        drive(0, 1'b1);
        idle(4 + $urandom_range(3));
      end else begin
        idle($urandom_range(2));
      end
    end

    idle(20);
    send(1, 8'h96, 1'b1, 1'b1, 1'b1);
    check("cpb16_d", d_b, 8'h96);
    for (int n = 0; n < 4; n++) begin
      send(1, 8'($urandom_range(255)), 1'b1, 1'b1, 1'b1);
      idle($urandom_range(3));
    end

    idle(10);
    check("pending_a", q_a.size(), 0);
    check("pending_b", q_b.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
